// File: rtl/uart_tx_piso.sv
// UART transmitter, parallel-in serial-out.
// Sends an 11-bit frame: start(0), data[0..7] LSB first, bit 9, stop(1).
// Each bit is held for one baud tick interval.
// Optional build macro UART_TX_PARITY_EN: bit 9 becomes even parity of data_in
// and priority_bit is ignored. When undefined, bit 9 is priority_bit.
module uart_tx_piso (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       tick,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  input  logic       priority_bit,
  output logic       uart_txd,
  output logic       busy,
  output logic       tx_done
);

  typedef enum logic [1:0] {StIdle, StArm, StSend} state_e;

  localparam logic [3:0] LastBit = 4'd10;

  state_e      state_q, state_d;
  logic [10:0] shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bit9;

`ifdef UART_TX_PARITY_EN
  assign bit9 = ^data_in;
  logic unused_priority_bit;
  assign unused_priority_bit = priority_bit;
`else
  assign bit9 = priority_bit;
`endif

  // Next-state and registered-output logic for the IDLE/ARM/SEND machine.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        // A tick in this cycle is deliberately not used; ARM waits for the next one.
        if (tx_start) begin
          shreg_d   = {1'b1, bit9, data_in, 1'b0};
          bit_cnt_d = 4'd0;
          state_d   = StArm;
          busy_d    = 1'b1;
        end
      end
      StArm: begin
        txd_d  = 1'b1;
        busy_d = 1'b1;
        // Aligning the start bit to a tick gives it a full bit period.
        if (tick) begin
          state_d = StSend;
          txd_d   = shreg_q[0];
        end
      end
      StSend: begin
        busy_d = 1'b1;
        if (tick) begin
          if (bit_cnt_q == LastBit) begin
            state_d = StIdle;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            shreg_d   = {1'b1, shreg_q[10:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            txd_d     = shreg_q[1];
          end
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q   <= StIdle;
      shreg_q   <= '1;
      bit_cnt_q <= 4'd0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign uart_txd = txd_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

endmodule
